// File: rtl/card_dealer.sv
// Card dealer: picks a start card from a free-running LFSR, probes linearly past
// already-dealt cards, and keeps hard/soft blackjack scores for player and dealer.
module card_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       deal_req,
    input  logic       target,
    input  logic       clear_hands,
    output logic       busy,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic [4:0] phand,
    output logic [4:0] dhand,
    output logic       reshuffled
);
    localparam int unsigned DECK      = 52;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned HARD_W    = 6;
    localparam int unsigned SCORE_W   = 5;
    localparam int unsigned SCORE_MAX = 31;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t            state;
    logic [15:0]       lfsr;
    logic [DECK-1:0]   used;
    logic [IDX_W-1:0]  count;
    logic [IDX_W-1:0]  idx;
    logic              tgt;
    logic [HARD_W-1:0] p_hard;
    logic [HARD_W-1:0] d_hard;
    logic              p_ace;
    logic              d_ace;

    logic [15:0]       lfsr_next;
    logic [IDX_W-1:0]  start_idx;
    logic [IDX_W-1:0]  probe_next;
    logic [IDX_W-1:0]  suit_base;
    logic [1:0]        cur_suit;
    logic [3:0]        cur_rank;
    logic [3:0]        cur_value;
    logic              is_ace;
    logic              slot_free;
    logic              commit;
    logic              deck_empty;
    logic [HARD_W-1:0] p_sum;
    logic [HARD_W-1:0] d_sum;
    logic              p_ace_next;
    logic              d_ace_next;

    // Hard total accumulation, clamped so a long hand never wraps.
    function automatic logic [HARD_W-1:0] sat_add(input logic [HARD_W-1:0] hard,
                                                   input logic [3:0]        value);
        logic [HARD_W:0] sum;
        sum = {1'b0, hard} + (HARD_W+1)'(value);
        return (sum > (HARD_W+1)'(SCORE_MAX)) ? HARD_W'(SCORE_MAX) : sum[HARD_W-1:0];
    endfunction

    // An ace counts as 11 only while that cannot bust the hand.
    function automatic logic [SCORE_W-1:0] best_score(input logic [HARD_W-1:0] hard,
                                                      input logic              ace);
        logic [HARD_W-1:0] best;
        best = (ace && (hard <= HARD_W'(11))) ? hard + HARD_W'(10) : hard;
        return (best > HARD_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : best[SCORE_W-1:0];
    endfunction

    always_comb begin
        lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        start_idx  = (lfsr[5:0] >= IDX_W'(DECK)) ? lfsr[5:0] - IDX_W'(DECK) : lfsr[5:0];
        probe_next = (idx == IDX_W'(DECK - 1)) ? '0 : idx + IDX_W'(1);
        cur_suit   = 2'd0;
        suit_base  = '0;
        if (idx >= IDX_W'(39)) begin
            cur_suit  = 2'd3;
            suit_base = IDX_W'(39);
        end else if (idx >= IDX_W'(26)) begin
            cur_suit  = 2'd2;
            suit_base = IDX_W'(26);
        end else if (idx >= IDX_W'(13)) begin
            cur_suit  = 2'd1;
            suit_base = IDX_W'(13);
        end
        cur_rank   = 4'(idx - suit_base) + 4'd1;
        cur_value  = (cur_rank > 4'd10) ? 4'd10 : cur_rank;
        is_ace     = (cur_rank == 4'd1);
        slot_free  = !used[idx];
        commit     = (state == SCAN) && slot_free;
        deck_empty = (count == IDX_W'(DECK));
        p_sum      = sat_add(p_hard, cur_value);
        d_sum      = sat_add(d_hard, cur_value);
        p_ace_next = p_ace | is_ace;
        d_ace_next = d_ace | is_ace;
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            used       <= '0;
            count      <= '0;
            idx        <= '0;
            tgt        <= 1'b0;
            p_hard     <= '0;
            d_hard     <= '0;
            p_ace      <= 1'b0;
            d_ace      <= 1'b0;
            busy       <= 1'b0;
            card_valid <= 1'b0;
            reshuffled <= 1'b0;
            card_rank  <= '0;
            card_suit  <= '0;
            phand      <= '0;
            dhand      <= '0;
        end else begin
            lfsr       <= lfsr_next;
            card_valid <= 1'b0;
            reshuffled <= 1'b0;
            case (state)
                IDLE: begin
                    if (deal_req) begin
                        tgt   <= target;
                        idx   <= start_idx;
                        state <= SCAN;
                        busy  <= 1'b1;
                        // Exhausted deck is refilled on the request that needs it.
                        if (deck_empty) begin
                            used       <= '0;
                            count      <= '0;
                            reshuffled <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (slot_free) begin
                        used[idx]  <= 1'b1;
                        count      <= count + IDX_W'(1);
                        card_rank  <= cur_rank;
                        card_suit  <= cur_suit;
                        card_valid <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        idx <= probe_next;
                    end
                end
            endcase
            // A clear overrides any simultaneous commit for the hands only.
            if (clear_hands) begin
                p_hard <= '0;
                d_hard <= '0;
                p_ace  <= 1'b0;
                d_ace  <= 1'b0;
                phand  <= '0;
                dhand  <= '0;
            end else if (commit) begin
                if (tgt) begin
                    d_hard <= d_sum;
                    d_ace  <= d_ace_next;
                    dhand  <= best_score(d_sum, d_ace_next);
                end else begin
                    p_hard <= p_sum;
                    p_ace  <= p_ace_next;
                    phand  <= best_score(p_sum, p_ace_next);
                end
            end
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: hand-scored vector table plus sequences for
// probing, deck exhaustion, held requests, coincident clear and mid-scan reset.
module tb_card_dealer;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int NV = 13;

    logic       Clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       deal_req    = 1'b0;
    logic       target      = 1'b0;
    logic       clear_hands = 1'b0;
    logic       busy;
    logic       card_valid;
    logic       reshuffled;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic [4:0] phand;
    logic [4:0] dhand;

    int          n_cmp    = 0;
    int          n_fail   = 0;
    int          m_count  = 0;
    logic [15:0] m_lfsr;
    logic [51:0] m_used   = '0;
    logic [51:0] dut_seen = '0;

    typedef struct {
        logic pre_clr;
        int   want;
        logic tgt;
        int   rank;
        int   suit;
        int   ph;
        int   dh;
        int   lat;
    } vec_t;
    vec_t vecs [NV];

    card_dealer #(.LFSR_SEED(SEED)) dut (
        .Clock       (Clock),
        .reset       (reset),
        .deal_req    (deal_req),
        .target      (target),
        .clear_hands (clear_hands),
        .busy        (busy),
        .card_valid  (card_valid),
        .card_rank   (card_rank),
        .card_suit   (card_suit),
        .phand       (phand),
        .dhand       (dhand),
        .reshuffled  (reshuffled)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference LFSR: value here at a falling edge is what the next rising edge sees.
    always @(posedge Clock or posedge reset)
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= lfsr_step(m_lfsr);

    function automatic int start_of(input logic [15:0] l);
        int r;
        r = int'(l[5:0]);
        return (r >= 52) ? r - 52 : r;
    endfunction

    function automatic int first_free(input int s, input logic [51:0] u);
        int i;
        i = s;
        for (int k = 0; k < 52; k++) begin
            if (!u[6'(i)]) return i;
            i = (i == 51) ? 0 : i + 1;
        end
        return -1;
    endfunction

    function automatic int dut_idx();
        return int'(card_suit) * 13 + int'(card_rank) - 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idx(input int want);
        for (int k = 0; k < 4000 && start_of(m_lfsr) != want; k++) @(negedge Clock);
        check("wait for start index", start_of(m_lfsr), want);
    endtask

    // One request from IDLE; returns at the falling edge after the card_valid pulse.
    task automatic do_deal(input logic tgt, input logic clr, input string tag, output int lat);
        int   s, x, sk, gi;
        logic resh;
        resh = (m_count == 52);
        if (resh) begin
            m_used   = '0;
            m_count  = 0;
            dut_seen = '0;
        end
        s   = start_of(m_lfsr);
        x   = first_free(s, m_used);
        sk  = (x - s + 52) % 52;
        lat = -1;
        deal_req = 1'b1;
        target   = tgt;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(negedge Clock);
            deal_req    = 1'b0;
            clear_hands = clr && (n == sk + 1);
            if (n == 1) begin
                check({tag, " busy"}, int'(busy), 1);
                check({tag, " reshuffled"}, int'(reshuffled), int'(resh));
            end
            if (card_valid) lat = n;
        end
        clear_hands = 1'b0;
        check({tag, " latency"}, lat, sk + 2);
        if (lat > 0) begin
            gi = dut_idx();
            check({tag, " card index"}, gi, x);
            check({tag, " busy at valid"}, int'(busy), 0);
            if (gi >= 0 && gi < 52) begin
                check({tag, " distinct"}, int'(dut_seen[6'(gi)]), 0);
                dut_seen[6'(gi)] = 1'b1;
            end
            @(negedge Clock);
            check({tag, " valid pulse width"}, int'(card_valid), 0);
        end
        m_used[6'(x)] = 1'b1;
        m_count++;
    endtask

    // deal_req held for 10 edges: one card per IDLE acceptance, the rest dropped.
    task automatic held_test();
        logic [15:0] lf;
        logic [51:0] u;
        int          e, s, x, sk, got;
        int          exp_n[$];
        int          exp_i[$];
        lf = m_lfsr;
        u  = m_used;
        e  = 0;
        while (e < 10) begin
            s  = start_of(lf);
            x  = first_free(s, u);
            sk = (x - s + 52) % 52;
            exp_n.push_back(e + sk + 2);
            exp_i.push_back(x);
            u[6'(x)] = 1'b1;
            m_count++;
            for (int j = 0; j < sk + 2; j++) lf = lfsr_step(lf);
            e += sk + 2;
        end
        got = exp_n.size();
        deal_req = 1'b1;
        target   = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge Clock);
            if (n >= 10) deal_req = 1'b0;
            if (card_valid) begin
                if (exp_n.size() > 0) begin
                    check("held valid cycle", n, exp_n.pop_front());
                    check("held card index", dut_idx(), exp_i.pop_front());
                end else begin
                    check("held extra card", n, 0);
                end
            end
        end
        check("held missing cards", exp_n.size(), 0);
        check("held cards expected", got, 5);
        m_used = u;
    endtask

    initial begin
        int lat;
        //           pre  want tgt  rank suit ph  dh  lat
        vecs[0]  = '{1'b0, 33, 1'b0,  8, 2,  8,  0, 2};
        vecs[1]  = '{1'b1,  0, 1'b0,  1, 0, 11,  0, 2};
        vecs[2]  = '{1'b0,  5, 1'b0,  6, 0, 17,  0, 2};
        vecs[3]  = '{1'b0, 22, 1'b0, 10, 1, 17,  0, 2};
        vecs[4]  = '{1'b0, 12, 1'b0, 13, 0, 27,  0, 2};
        vecs[5]  = '{1'b0, 30, 1'b1,  5, 2, 27,  5, 2};
        vecs[6]  = '{1'b0, 51, 1'b1, 13, 3, 27, 15, 2};
        vecs[7]  = '{1'b0, 39, 1'b1,  1, 3, 27, 16, 2};
        vecs[8]  = '{1'b0, 13, 1'b0,  1, 1, 28, 16, 2};
        vecs[9]  = '{1'b0, 40, 1'b0,  2, 3, 30, 16, 2};
        vecs[10] = '{1'b0, 45, 1'b0,  7, 3, 31, 16, 2};
        vecs[11] = '{1'b0, 34, 1'b1,  9, 2, 31, 25, 2};
        vecs[12] = '{1'b0, 33, 1'b1, 10, 2, 31, 31, 4};

        repeat (3) @(negedge Clock);
        check("reset busy", int'(busy), 0);
        check("reset card_valid", int'(card_valid), 0);
        check("reset reshuffled", int'(reshuffled), 0);
        check("reset card_rank", int'(card_rank), 0);
        check("reset card_suit", int'(card_suit), 0);
        check("reset phand", int'(phand), 0);
        check("reset dhand", int'(dhand), 0);
        reset = 1'b0;

        for (int v = 0; v < NV; v++) begin
            if (vecs[v].pre_clr) begin
                clear_hands = 1'b1;
                @(negedge Clock);
                clear_hands = 1'b0;
                check("idle clear phand", int'(phand), 0);
                check("idle clear dhand", int'(dhand), 0);
            end
            wait_idx(vecs[v].want);
            do_deal(vecs[v].tgt, 1'b0, $sformatf("vec%0d", v), lat);
            check($sformatf("vec%0d table latency", v), lat, vecs[v].lat);
            check($sformatf("vec%0d rank", v), int'(card_rank), vecs[v].rank);
            check($sformatf("vec%0d suit", v), int'(card_suit), vecs[v].suit);
            check($sformatf("vec%0d phand", v), int'(phand), vecs[v].ph);
            check($sformatf("vec%0d dhand", v), int'(dhand), vecs[v].dh);
        end

        do_deal(1'b0, 1'b1, "coincident clear", lat);
        check("coincident phand", int'(phand), 0);
        check("coincident dhand", int'(dhand), 0);

        while (m_count < 52) do_deal((m_count % 2) == 1, 1'b0, $sformatf("bulk%0d", m_count), lat);
        check("deck full", m_count, 52);
        check("all dealt", int'($countones(dut_seen)), 52);
        do_deal(1'b0, 1'b0, "deck53", lat);

        held_test();

        // Reset in the SCAN cycle must drop the card.
        @(negedge Clock);
        deal_req = 1'b1;
        target   = 1'b0;
        @(negedge Clock);
        deal_req = 1'b0;
        check("pre-abort busy", int'(busy), 1);
        reset = 1'b1;
        m_used   = '0;
        m_count  = 0;
        dut_seen = '0;
        for (int n = 0; n < 3; n++) begin
            @(negedge Clock);
            check("abort card_valid", int'(card_valid), 0);
        end
        check("abort busy", int'(busy), 0);
        check("abort card_rank", int'(card_rank), 0);
        check("abort dhand", int'(dhand), 0);
        reset = 1'b0;
        do_deal(1'b1, 1'b0, "post reset", lat);
        check("post reset rank", int'(card_rank), 8);
        check("post reset suit", int'(card_suit), 2);
        check("post reset dhand", int'(dhand), 8);
        check("post reset phand", int'(phand), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
